serial_add_ctrl: RTL and testbench

- Sequencer that runs WIDTH-bit add/subtract operations through one shared 1-bit full-adder cell, one bit per clock, LSB first.
- Latches operands on a start handshake, shifts them through the cell, carries the result between bits in a register, and reports sum, carry-out and signed overflow with a one-cycle done pulse.
- Intended as the area-minimal arithmetic unit beside the combinational adder cells in the same library.

---
 rtl/serial_add_pkg.sv | 8 +
 rtl/serial_add_ctrl_if.sv | 16 +
 rtl/serial_add_ctrl_fa_cell.sv | 11 +
 rtl/serial_add_ctrl.sv | 83 ++++++++
 tb/tb_serial_add_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add/subtract sequencer.
package serial_add_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a client and the serial adder.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (output start, sub, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, sub, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder; the single arithmetic resource time-shared by the sequencer.
module fa_cell (
    input  logic cin,
    input  logic a,
    input  logic b,
    output logic r,
    output logic cout
);
    assign r    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// WIDTH-bit add/subtract computed LSB first through one full-adder cell,
// one bit per clock, with carry-out, signed overflow and a done pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic             carry, c_msb, cout_r, ovf_r;
    logic             fa_r, fa_co;
    logic             accept, last;

    fa_cell u_fa (
        .cin  (carry),
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .r    (fa_r),
        .cout (fa_co)
    );

    assign accept = (state == IDLE || state == DONE) && bus.start;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.start) nxt = RUN;
            RUN:     if (last) nxt = DONE;
            DONE:    nxt = bus.start ? RUN : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            c_msb  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                // Subtract is a + ~b + 1; the +1 rides in on the initial carry.
                a_sr  <= bus.a;
                b_sr  <= bus.sub ? ~bus.b : bus.b;
                carry <= bus.sub ? 1'b1 : bus.cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                sum_sr <= {fa_r, sum_sr[WIDTH-1:1]};
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                carry  <= fa_co;
                // Carry produced by bit WIDTH-2 is the carry into the MSB.
                if (cnt == CNT_W'(WIDTH - 2)) c_msb <= fa_co;
                if (last) begin
                    cout_r <= fa_co;
                    ovf_r  <= c_msb ^ fa_co;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_sr;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl against an arithmetic model.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sb, output logic [W-1:0] s, output logic co,
                         output logic ov);
        logic [W-1:0] bb;
        logic [W:0]   tot;
        bb  = sb ? ~b : b;
        tot = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
        s   = tot[W-1:0];
        co  = tot[W];
        ov  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    endtask

    // Drives a request and returns 1ns after the edge that samples it.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb);
        bus.a = a; bus.b = b; bus.cin = ci; bus.sub = sb; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic ci, input logic sb);
        logic [W-1:0] es;
        logic eco, eov;
        int n;
        bit seen;
        model(a, b, ci, sb, es, eco, eov);
        n = 0; seen = 0;
        while (n < 4 * W && !seen) begin
            @(posedge clk); #1;
            n++;
            chk({tag, ".busy_done"}, {62'd0, bus.busy, bus.done} == 64'd3, 64'd0);
            seen = bus.done;
        end
        chk({tag, ".timeout"}, seen, 1'b1);
        if (seen) begin
            chk({tag, ".lat"}, n, W);
            chk({tag, ".sum"}, bus.sum, es);
            chk({tag, ".cout"}, bus.cout, eco);
            chk({tag, ".ovf"}, bus.ovf, eov);
        end
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic sb);
        launch(a, b, ci, sb);
        wait_done(tag, a, b, ci, sb);
    endtask

    task automatic no_done(input string tag, input int cyc);
        int hits = 0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk); #1;
            if (bus.done) hits++;
        end
        chk(tag, hits, 0);
    endtask

    initial begin
        bus.start = 0; bus.sub = 0; bus.a = '0; bus.b = '0; bus.cin = 0;
        #12;
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.sum",  bus.sum, 0);
        chk("rst.cout", bus.cout, 0);
        chk("rst.ovf",  bus.ovf, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        op("add", 8'h0F, 8'h01, 0, 0);
        @(negedge clk);
        op("wrap", 8'hFF, 8'h01, 0, 0);
        @(negedge clk);
        op("sovf", 8'h7F, 8'h01, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold", bus.sum, 8'h80);
        end
        op("sub_borrow", 8'h05, 8'h07, 1, 1);
        @(negedge clk);
        op("sub_ovf", 8'h80, 8'h01, 0, 1);
        @(negedge clk);

        // start while RUN must be ignored and not re-sample operands
        launch(8'h03, 8'h04, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.a = 8'hAA; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        begin
            int n = 3;
            bit seen = 0;
            while (n < 4 * W && !seen) begin
                @(posedge clk); #1;
                n++;
                seen = bus.done;
            end
            chk("ign.seen", seen, 1'b1);
            chk("ign.lat", n, W);
            chk("ign.sum", bus.sum, 8'h07);
        end
        no_done("ign.second", 3 * W);

        // back-to-back: new start held in the done cycle
        op("b2b.1", 8'h11, 8'h22, 0, 0);
        op("b2b.2", 8'h10, 8'h20, 0, 0);
        @(negedge clk);

        // asynchronous reset between edges in the middle of RUN
        launch(8'h55, 8'h0A, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy", bus.busy, 0);
        chk("arst.done", bus.done, 0);
        chk("arst.sum",  bus.sum, 0);
        chk("arst.cout", bus.cout, 0);
        chk("arst.ovf",  bus.ovf, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        no_done("arst.nodone", 2 * W);
        op("arst.fresh", 8'h01, 8'h01, 0, 0);

        // random operations, some chained back-to-back
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra, rb;
            logic rc, rs;
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            op("rand", ra, rb, rc, rs);
            if ($urandom_range(3) != 0) begin
                int idle = $urandom_range(1, 4);
                for (int j = 0; j < idle; j++) begin
                    @(negedge clk);
                    bus.a = W'($urandom); bus.b = W'($urandom);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
